// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between an instruction-fetch port and a load/store port.
// Each access walks IDLE -> ISSUE -> RESP -> ACK; ties go round-robin.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_ls;

  // Next-state and registered-output logic; the latched access lives in mem_addr_q/mem_wdata_q/we_q.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    ls_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    grant_ls     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          grant_ls     = ls_req && (!if_req || (last_grant_q == OWN_IF));
          owner_d      = grant_ls ? OWN_LS : OWN_IF;
          last_grant_d = grant_ls ? OWN_LS : OWN_IF;
          we_d         = grant_ls && ls_we;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_ls && ls_we;
          mem_addr_d   = grant_ls ? ls_addr : if_addr;
          if (grant_ls) mem_wdata_d = ls_wdata;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        // RAM data is valid this cycle; capture it alongside the ack so both appear together.
        state_d = ST_ACK;
        if (owner_q == OWN_IF) begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end else begin
          ls_ack_d = 1'b1;
          if (!we_q) ls_rdata_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      ls_ack_q     <= ls_ack_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a vector table of single accesses plus hand-written
// sequences for contention, late input changes, reset during an access and idle.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [11:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM stand-in: read data one cycle after mem_en.
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [7];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_if = 32'h0;
  logic [31:0] exp_ls = 32'h0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One isolated access, checked cycle by cycle from request (N) to the idle cycle after ack.
  task automatic do_access(input logic is_ls, input logic we, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk);
    chk1("n_mem_en", mem_en, 1'b0);
    chk1("n_busy", busy, 1'b0);
    @(negedge clk);
    chk1("issue_mem_en", mem_en, 1'b1);
    chk32("issue_addr", 32'(mem_addr), 32'(addr));
    chk1("issue_we", mem_we, is_ls & we);
    if (is_ls && we) chk32("issue_wdata", mem_wdata, wdata);
    chk1("issue_busy", busy, 1'b1);
    @(negedge clk);
    chk1("resp_mem_en", mem_en, 1'b0);
    chk1("resp_acks", if_ack | ls_ack, 1'b0);
    @(negedge clk);
    if (!is_ls) exp_if = rdata;
    else if (!we) exp_ls = rdata;
    chk1("ack_if", if_ack, !is_ls);
    chk1("ack_ls", ls_ack, is_ls);
    chk32("ack_if_rdata", if_rdata, exp_if);
    chk32("ack_ls_rdata", ls_rdata, exp_ls);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk1("post_acks", if_ack | ls_ack, 1'b0);
    chk1("post_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 12'h005, 32'h0,        32'h8C220004};
    vecs[1] = '{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 12'hFFF, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 12'h000, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b1, 1'b1, 12'hFFF, 32'hCAFEF00D, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 12'hFFF, 32'h0,        32'hCAFEF00D};

    ram[12'h000] = 32'hA5A5A5A5;
    ram[12'h005] = 32'h8C220004;
    ram[12'h010] = 32'h11111111;
    ram[12'h020] = 32'h22222222;
    ram[12'hFFF] = 32'h12345678;

    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_acks", if_ack | ls_ack, 1'b0);
    chk32("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_ls_rdata", ls_rdata, 32'h0);

    // Contention right out of reset: LS first, then strict alternation every 4 cycles.
    @(posedge clk); #1;
    reset = 1'b0;
    if_req = 1'b1; if_addr = 12'h005;
    ls_req = 1'b1; ls_addr = 12'h010; ls_we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk1("rr_ls_ack", ls_ack, (c == 3) || (c == 11));
      chk1("rr_if_ack", if_ack, (c == 7) || (c == 15));
      chk1("rr_mem_en", mem_en, (c % 4) == 1);
      if (c == 3)  chk32("rr_ls_rdata", ls_rdata, 32'h11111111);
      if (c == 7)  chk32("rr_if_rdata", if_rdata, 32'h8C220004);
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    exp_if = 32'h8C220004;
    exp_ls = 32'h11111111;

    for (int i = 0; i < 7; i++)
      do_access(vecs[i].is_ls, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

    // Address changed during ISSUE must not affect the access already latched.
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h010;
    @(posedge clk); #1;
    ls_addr = 12'h020;
    @(negedge clk);
    chk32("late_mem_addr", 32'(mem_addr), 32'h010);
    @(negedge clk);
    @(negedge clk);
    chk1("late_ls_ack", ls_ack, 1'b1);
    chk32("late_ls_rdata", ls_rdata, 32'hDEADBEEF);
    exp_ls = 32'hDEADBEEF;
    @(posedge clk); #1;
    ls_req = 1'b0;

    // Reset during RESP of a load aborts it; the reissued load then completes.
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h000;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk1("abort_ls_ack", ls_ack, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk32("abort_ls_rdata", ls_rdata, 32'h0);
    chk32("abort_if_rdata", if_rdata, 32'h0);
    exp_if = 32'h0;
    exp_ls = 32'h0;
    do_access(1'b1, 1'b0, 12'h000, 32'h0, 32'hA5A5A5A5);

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk1("idle_mem_en", mem_en, 1'b0);
      chk1("idle_acks", if_ack | ls_ack, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
